// File: rtl/axis_testpattern_scheduler.sv
// Frame sequencer between an AXI-Stream pattern source and its consumer.
// It gates the source, frames beats with tlast, inserts idle gaps and stops on count or request.
module axis_testpattern_scheduler #(
    parameter int TDATA_WIDTH = 32,
    parameter int LEN_WIDTH   = 16,
    parameter int CNT_WIDTH   = 16,
    parameter int GAP_WIDTH   = 16
) (
    input  logic                   m_axis_aclk,
    input  logic                   m_axis_aresetn,
    input  logic                   start,
    input  logic                   stop,
    input  logic [LEN_WIDTH-1:0]   cfg_frame_len,
    input  logic [CNT_WIDTH-1:0]   cfg_num_frames,
    input  logic [GAP_WIDTH-1:0]   cfg_gap,
    output logic                   gen_enable,
    input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_WIDTH-1:0]   frame_count
);

    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0] LEN_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [GAP_WIDTH-1:0] GAP_ONE  = GAP_WIDTH'(1);
    localparam logic [GAP_WIDTH-1:0] GAP_ZERO = '0;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_DONE} state_t;

    state_t               state;
    logic [LEN_WIDTH-1:0] len_r;
    logic [LEN_WIDTH-1:0] beat;
    logic [CNT_WIDTH-1:0] num_r;
    logic [GAP_WIDTH-1:0] gap_r;
    logic [GAP_WIDTH-1:0] gap_cnt;
    logic                 stop_pending;

    logic                 xfer;
    logic                 last_beat;
    logic [CNT_WIDTH-1:0] fc_next;
    logic                 reach_count;

    // gen_enable is the registered RUN flag, so it also qualifies the pass-through path
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tvalid = gen_enable & s_axis_tvalid;
    assign s_axis_tready = gen_enable & m_axis_tready;
    assign last_beat     = (beat == (len_r - LEN_ONE));
    assign m_axis_tlast  = gen_enable & last_beat;

    assign xfer        = m_axis_tvalid & m_axis_tready;
    assign fc_next     = frame_count + CNT_ONE;
    assign reach_count = (num_r != CNT_ZERO) && (fc_next == num_r);

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            state        <= S_IDLE;
            gen_enable   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            frame_count  <= CNT_ZERO;
            stop_pending <= 1'b0;
            beat         <= LEN_ZERO;
            gap_cnt      <= GAP_ZERO;
            len_r        <= LEN_ONE;
            num_r        <= CNT_ZERO;
            gap_r        <= GAP_ZERO;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        len_r        <= (cfg_frame_len == LEN_ZERO) ? LEN_ONE : cfg_frame_len;
                        num_r        <= cfg_num_frames;
                        gap_r        <= cfg_gap;
                        beat         <= LEN_ZERO;
                        gap_cnt      <= GAP_ZERO;
                        frame_count  <= CNT_ZERO;
                        stop_pending <= 1'b0;
                        state        <= S_RUN;
                        gen_enable   <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        stop_pending <= 1'b1;
                    end
                    if (xfer) begin
                        if (last_beat) begin
                            beat        <= LEN_ZERO;
                            frame_count <= fc_next;
                            if (stop_pending || stop || reach_count) begin
                                state      <= S_DONE;
                                gen_enable <= 1'b0;
                                busy       <= 1'b0;
                                done       <= 1'b1;
                            end else if (gap_r != GAP_ZERO) begin
                                // Down-count so the gap lasts exactly gap_r cycles
                                state      <= S_GAP;
                                gen_enable <= 1'b0;
                                gap_cnt    <= gap_r - GAP_ONE;
                            end
                        end else begin
                            beat <= beat + LEN_ONE;
                        end
                    end
                end
                S_GAP: begin
                    if (stop) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (gap_cnt == GAP_ZERO) begin
                        state      <= S_RUN;
                        gen_enable <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_ONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state      <= S_IDLE;
                    gen_enable <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_testpattern_scheduler.sv
// Bench for axis_testpattern_scheduler: directed scenarios against a beat-queue and gap-length model.
`timescale 1ns/1ps
module tb_axis_testpattern_scheduler;

    localparam int TDATA_WIDTH = 32;
    localparam int LEN_WIDTH   = 16;
    localparam int CNT_WIDTH   = 16;
    localparam int GAP_WIDTH   = 16;

    logic                   clk = 1'b0;
    logic                   aresetn = 1'b0;
    logic                   start = 1'b0;
    logic                   stop = 1'b0;
    logic [LEN_WIDTH-1:0]   cfg_frame_len = '0;
    logic [CNT_WIDTH-1:0]   cfg_num_frames = '0;
    logic [GAP_WIDTH-1:0]   cfg_gap = '0;
    logic                   gen_enable;
    logic [TDATA_WIDTH-1:0] s_axis_tdata;
    logic                   s_axis_tvalid = 1'b1;
    logic                   s_axis_tready;
    logic [TDATA_WIDTH-1:0] m_axis_tdata;
    logic                   m_axis_tvalid;
    logic                   m_axis_tready = 1'b1;
    logic                   m_axis_tlast;
    logic                   busy;
    logic                   done;
    logic [CNT_WIDTH-1:0]   frame_count;

    logic [TDATA_WIDTH-1:0] src_data = '0;
    assign s_axis_tdata = src_data;

    axis_testpattern_scheduler #(
        .TDATA_WIDTH(TDATA_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH),
        .GAP_WIDTH  (GAP_WIDTH)
    ) dut (
        .m_axis_aclk   (clk),
        .m_axis_aresetn(aresetn),
        .start         (start),
        .stop          (stop),
        .cfg_frame_len (cfg_frame_len),
        .cfg_num_frames(cfg_num_frames),
        .cfg_gap       (cfg_gap),
        .gen_enable    (gen_enable),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .done          (done),
        .frame_count   (frame_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [TDATA_WIDTH-1:0] data;
        logic                   last;
    } beat_t;

    beat_t exp_q[$];
    int    mdl_frames = 0;
    int    exp_gap = 0;
    int    gap_len = 0;
    int    gap_total = 0;
    int    done_seen = 0;
    int    done_cyc = 0;
    int    last_hs_cyc = 0;
    bit    gap_track = 0;
    bit    toggle_ready = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the beat queue, frame tally and gap-length expectation
    always @(negedge clk) begin
        chk("tvalid_rule", m_axis_tvalid, gen_enable & s_axis_tvalid);
        chk("tready_rule", s_axis_tready, gen_enable & m_axis_tready);
        chk("tdata_pass", m_axis_tdata, s_axis_tdata);
        if (!gen_enable) chk("tlast_outside_run", m_axis_tlast, 0);
        if (gen_enable) chk("busy_in_run", busy, 1);
        if (done) chk("done_not_busy", busy, 0);
        if (busy || done) chk("frame_count", frame_count, mdl_frames);
        if (done) begin
            done_seen++;
            done_cyc = cyc;
        end
        if (gap_track) begin
            if (!busy) begin
                gap_track = 0;
            end else if (gen_enable) begin
                chk("gap_len", gap_len, exp_gap);
                gap_track = 0;
            end else begin
                gap_len++;
                gap_total++;
            end
        end
        if (m_axis_tvalid && m_axis_tready) chk("beat_expected", exp_q.size() > 0, 1);
        if (m_axis_tvalid && exp_q.size() > 0) begin
            chk("beat_data", m_axis_tdata, exp_q[0].data);
            chk("beat_last", m_axis_tlast, exp_q[0].last);
            if (m_axis_tready) begin
                if (exp_q[0].last) begin
                    mdl_frames++;
                    last_hs_cyc = cyc;
                    gap_track = 1;
                    gap_len = 0;
                end
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic step();
        logic hs;
        @(negedge clk);
        hs = m_axis_tvalid && m_axis_tready;
        @(posedge clk);
        #1;
        if (hs) src_data = src_data + 1;
        if (toggle_ready) m_axis_tready = ~m_axis_tready;
    endtask

    task automatic do_start(input int len, input int frames, input int gap, input int nframes_exp);
        int leff;
        beat_t b;
        leff = (len == 0) ? 1 : len;
        cfg_frame_len  = LEN_WIDTH'(len);
        cfg_num_frames = CNT_WIDTH'(frames);
        cfg_gap        = GAP_WIDTH'(gap);
        exp_q.delete();
        for (int i = 0; i < nframes_exp * leff; i++) begin
            b.data = src_data + TDATA_WIDTH'(i);
            b.last = ((i % leff) == leff - 1);
            exp_q.push_back(b);
        end
        mdl_frames = 0;
        exp_gap    = gap;
        gap_total  = 0;
        gap_track  = 0;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int d0;
        int n;
        d0 = done_seen;
        n  = 0;
        while (done_seen == d0 && n < 400) begin
            step();
            n++;
        end
        chk({name, "_done_pulses"}, done_seen - d0, 1);
        chk({name, "_queue_empty"}, exp_q.size(), 0);
        chk({name, "_idle_busy"}, busy, 0);
        chk({name, "_idle_done"}, done, 0);
        chk({name, "_idle_gen_enable"}, gen_enable, 0);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_gen_enable"}, gen_enable, 0);
        chk({name, "_s_tready"}, s_axis_tready, 0);
        chk({name, "_m_tvalid"}, m_axis_tvalid, 0);
        chk({name, "_m_tlast"}, m_axis_tlast, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_done"}, done, 0);
        chk({name, "_frame_count"}, frame_count, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        #1;
        chk_reset_outputs("reset");
        step();
        step();
        aresetn = 1'b1;
        step();
        chk_reset_outputs("post_reset");

        // len=4, frames=2, gap=3, always ready
        src_data = 0;
        do_start(4, 2, 3, 2);
        wait_done("t1");
        chk("t1_frame_count", frame_count, 2);
        chk("t1_done_after_last", done_cyc - last_hs_cyc, 1);
        chk("t1_gap_total", gap_total, 3);
        chk("t1_beats_sent", src_data, 8);

        // Same with consumer ready toggling
        src_data = 0;
        m_axis_tready = 1'b1;
        toggle_ready = 1;
        do_start(4, 2, 3, 2);
        wait_done("t2");
        toggle_ready = 0;
        m_axis_tready = 1'b1;
        chk("t2_frame_count", frame_count, 2);
        chk("t2_beats_sent", src_data, 8);

        // Continuous len=8, stop during beat 1
        src_data = 0;
        do_start(8, 0, 5, 1);
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_done("t3");
        chk("t3_frame_count", frame_count, 1);
        chk("t3_gen_enable", gen_enable, 0);
        chk("t3_beats_sent", src_data, 8);

        // len=0 treated as 1, three back-to-back frames
        src_data = 0;
        do_start(0, 3, 0, 3);
        wait_done("t4");
        chk("t4_frame_count", frame_count, 3);
        chk("t4_done_after_last", done_cyc - last_hs_cyc, 1);
        chk("t4_gap_total", gap_total, 0);
        chk("t4_beats_sent", src_data, 3);

        // Reset during beat 2 of a len=4 frame
        src_data = 0;
        do_start(4, 1, 0, 1);
        step();
        step();
        aresetn = 1'b0;
        #1;
        chk_reset_outputs("t5_reset");
        chk("t5_beats_before_reset", src_data, 2);
        exp_q.delete();
        gap_track = 0;
        step();
        step();
        aresetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t5_quiet_tvalid", m_axis_tvalid, 0);
            chk("t5_quiet_busy", busy, 0);
        end
        do_start(4, 1, 0, 1);
        wait_done("t5");
        chk("t5_frame_count", frame_count, 1);
        chk("t5_beats_sent", src_data, 6);

        // start ignored in GAP, stop in GAP ends the run next cycle
        src_data = 0;
        do_start(2, 3, 4, 2);
        n = 0;
        while (mdl_frames < 1 && n < 100) begin
            step();
            n++;
        end
        chk("t6_first_frame", mdl_frames, 1);
        chk("t6_in_gap", {busy, gen_enable}, 2'b10);
        cfg_frame_len  = 5;
        cfg_gap        = 1;
        cfg_num_frames = 1;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (mdl_frames < 2 && n < 100) begin
            step();
            n++;
        end
        chk("t6_second_frame", mdl_frames, 2);
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t6_done_next", done, 1);
        chk("t6_busy_low", busy, 0);
        chk("t6_frame_count", frame_count, 2);
        step();
        chk("t6_queue_empty", exp_q.size(), 0);
        chk("t6_idle_done", done, 0);
        chk("t6_gap_total", gap_total, 6);
        chk("t6_beats_sent", src_data, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_testpattern_scheduler.md
# axis_testpattern_scheduler

Sequencer placed between an AXI-Stream test-pattern source and its consumer. Gates the source's enable, frames the stream into fixed-length packets with `tlast`, inserts programmable idle gaps between frames, and stops after a programmed frame count or on request. Software or a top-level FSM drives it through `start`, `stop` and the configuration inputs.

## Interface
- `TDATA_WIDTH`, 32, stream data width
- `LEN_WIDTH`, 16, width of `cfg_frame_len` and the beat counter
- `CNT_WIDTH`, 16, width of `cfg_num_frames` and `frame_count`
- `GAP_WIDTH`, 16, width of `cfg_gap` and the gap counter

- `m_axis_aclk`  in  1  clock
- `m_axis_aresetn`  in  1  reset, asynchronous, active-low
- `start`  in  1  single-cycle start request
- `stop`  in  1  single-cycle graceful stop request
- `cfg_frame_len`  in  LEN_WIDTH  beats per frame; 0 is treated as 1
- `cfg_num_frames`  in  CNT_WIDTH  frames to send; 0 means continuous
- `cfg_gap`  in  GAP_WIDTH  idle cycles between frames
- `gen_enable`  out  1  enable to the pattern source
- `s_axis_tdata`  in  TDATA_WIDTH  source data
- `s_axis_tvalid`  in  1  source valid
- `s_axis_tready`  out  1  ready to source
- `m_axis_tdata`  out  TDATA_WIDTH  forwarded data
- `m_axis_tvalid`  out  1  forwarded valid
- `m_axis_tready`  in  1  consumer ready
- `m_axis_tlast`  out  1  last beat of frame
- `busy`  out  1  high in RUN or GAP
- `done`  out  1  one-cycle pulse on completion
- `frame_count`  out  CNT_WIDTH  frames completed since last start

## Operation
- States: IDLE, RUN, GAP, DONE. Reset enters IDLE.
- IDLE:
  - On `start`, latch `max(cfg_frame_len,1)`, `cfg_num_frames` and `cfg_gap`.
  - Clear the beat counter, gap counter, `frame_count` and stop_pending, then go to RUN.
  - `stop` is ignored in IDLE. `start` and `stop` in the same cycle: start wins, stop is discarded.
- RUN:
  - Pass-through: `m_axis_tdata = s_axis_tdata`, `m_axis_tvalid = s_axis_tvalid`, `s_axis_tready = m_axis_tready`.
  - `m_axis_tlast = (beat == len-1)`. A beat counts only when `m_axis_tvalid & m_axis_tready`.
  - On a non-last beat: beat increments.
  - On the last beat: beat clears and `frame_count` increments (wraps in continuous mode). The next state is:
    - DONE if stop_pending, or a stop arrives this cycle, or the new `frame_count == num_frames` with `num_frames != 0`;
    - otherwise GAP if `gap != 0`;
    - otherwise RUN.
  - `stop` during RUN sets stop_pending. The current frame always completes.
- GAP:
  - Counts `gap` cycles, then returns to RUN.
  - `stop` in GAP goes to DONE next cycle.
- DONE: lasts one cycle with `done=1`, then goes to IDLE.
- Outside RUN: `m_axis_tvalid=0`, `s_axis_tready=0`, `m_axis_tlast=0`, `m_axis_tdata=s_axis_tdata`. The source holds its pending beat.
- `gen_enable` is registered: 1 exactly while state is RUN.
- `start` during RUN, GAP or DONE is ignored. Configuration changes after `start` have no effect until the next start.
- Counter widths follow their parameters. Comparisons are unsigned.

## Timing
- Reset values: `gen_enable=0`, `s_axis_tready=0`, `m_axis_tvalid=0`, `m_axis_tlast=0`, `busy=0`, `done=0`, `frame_count=0`, state IDLE.
- `start` sampled at cycle N: RUN, `gen_enable=1` and `busy=1` at N+1. The first beat can transfer at N+1.
- Data path is combinational, with zero latency in RUN.
- Last beat of a frame at cycle K:
  - If GAP follows: GAP for cycles K+1..K+gap, RUN again at K+gap+1.
  - If `gap=0`: the next frame's beats may transfer at K+1.
- Completion at cycle K: `done=1` and `busy=0` at K+1; IDLE at K+2, where a new `start` is accepted.
- `stop` in GAP at cycle G: DONE at G+1.
- Reset asserted mid-frame: all outputs go to reset values immediately. No partial frame resumes; a new `start` is required.

## Test plan
- len=4, frames=2, gap=3, tready=1, source data 0,1,2,…:
  - beats 0–3 then 4–7; `tlast` on data 3 and 7;
  - exactly 3 cycles with `tvalid=0` between frames;
  - `done` one cycle after data 7, `frame_count=2`.
- Same configuration with `tready` toggling 1,0,1,0: data 0–7 delivered once each in order; `tlast` only on the accepted 4th and 8th beats.
- len=8, frames=0, `stop` pulsed during beat 1: beats continue to data 7 with `tlast`, then DONE, `frame_count=1`, `gen_enable` low.
- len=0, frames=3, gap=0: three back-to-back single-beat frames, `tlast=1` on each, `done` after the third.
- Reset pulsed during beat 2 of a len=4 frame: all outputs at reset values; no output until the next `start`, after which the frame restarts at beat 0.
- `start` pulsed during GAP: ignored, and the configuration is unchanged. `stop` during GAP: DONE the next cycle with `frame_count` unchanged.
